seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 94 +++++++++
 tb/tb_seq_detector_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parameterised serial sequence detector: N-bit history window, Moore match flag,
// optional overlapping matches and a saturating match counter with its own clear.
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w,
    input  logic             clr,
    output logic             z,
    output logic [CNT_W-1:0] count
);

    localparam int               FW      = $clog2(N + 1);
    localparam logic [FW-1:0]    F_FULL  = FW'(N);
    localparam logic [FW-1:0]    F_ONE   = FW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N-1:0]     h_r;
    logic [FW-1:0]    f_r;
    logic             z_r;
    logic [CNT_W-1:0] count_r;

    logic [N-1:0]     h_s;
    logic [FW-1:0]    f_s;
    logic             z_s;
    logic             match_s;
    logic [CNT_W-1:0] count_s;

    // Next history, fill level and match flag for the coming edge.
    always_comb begin
        h_s = h_r;
        f_s = f_r;
        if (en) begin
            h_s = {h_r[N-2:0], w};
            // Without overlap the bit sampled while z is high opens a new window.
            if ((OVERLAP == 0) && z_r) begin
                f_s = F_ONE;
            end else if (f_r == F_FULL) begin
                f_s = F_FULL;
            end else begin
                f_s = f_r + F_ONE;
            end
        end else begin
            h_s = h_r;
            f_s = f_r;
        end
        z_s     = (f_s == F_FULL) && (h_s == PATTERN);
        match_s = en && z_s;
    end

    // Next counter value: clear wins over a saturating increment.
    always_comb begin
        count_s = count_r;
        if (clr) begin
            count_s = {CNT_W{1'b0}};
        end else if (match_s && (count_r != CNT_MAX)) begin
            count_s = count_r + CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Detector state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_r <= {N{1'b0}};
            f_r <= {FW{1'b0}};
            z_r <= 1'b0;
        end else begin
            h_r <= h_s;
            f_r <= f_s;
            z_r <= z_s;
        end
    end

    // Match counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

    assign z     = z_r;
    assign count = count_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench: four detector configurations share one stimulus
// stream, and each scenario task checks the instance it targets.
module tb_seq_detector_param;

    logic clk;
    logic rst;
    logic en;
    logic w;
    logic clr;

    logic       z_ov, z_no, z_sat, z_one;
    logic [7:0] cnt_ov, cnt_no, cnt_one;
    logic [1:0] cnt_sat;

    int checks;
    int errors;

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .en(en), .w(w), .clr(clr), .z(z_ov), .count(cnt_ov));
    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_no (
        .clk(clk), .rst(rst), .en(en), .w(w), .clr(clr), .z(z_no), .count(cnt_no));
    seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .w(w), .clr(clr), .z(z_sat), .count(cnt_sat));
    seq_detector_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(8)) dut_one (
        .clk(clk), .rst(rst), .en(en), .w(w), .clr(clr), .z(z_one), .count(cnt_one));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic e, input logic b);
        en = e;
        w  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b1, 1'b1);
        rst = 1'b1;
        en  = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        do_reset();
        clr = 1'b0;
        checks++;
        if (z_ov !== 1'b0 || z_no !== 1'b0 || z_sat !== 1'b0 || z_one !== 1'b0) begin
            errors++;
            $display("FAIL reset_z: got %b%b%b%b expected 0000", z_ov, z_no, z_sat, z_one);
        end
        checks++;
        if (cnt_ov !== 8'd0 || cnt_no !== 8'd0 || cnt_sat !== 2'd0 || cnt_one !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d %0d %0d %0d expected 0 0 0 0",
                     cnt_ov, cnt_no, cnt_sat, cnt_one);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] exp_ov;
        logic [6:0] exp_no;
        bits   = 7'b1011011;
        exp_ov = 7'b0001001;
        exp_no = 7'b0001000;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, bits[i]);
            checks++;
            if (z_ov !== exp_ov[i]) begin
                errors++;
                $display("FAIL overlap_z bit%0d: got %b expected %b", 7 - i, z_ov, exp_ov[i]);
            end
            checks++;
            if (z_no !== exp_no[i]) begin
                errors++;
                $display("FAIL nonoverlap_z bit%0d: got %b expected %b", 7 - i, z_no, exp_no[i]);
            end
        end
        checks++;
        if (cnt_ov !== 8'd2) begin
            errors++;
            $display("FAIL overlap_count: got %0d expected 2", cnt_ov);
        end
        checks++;
        if (cnt_no !== 8'd1) begin
            errors++;
            $display("FAIL nonoverlap_count: got %0d expected 1", cnt_no);
        end
    endtask

    task automatic test_nonoverlap_fresh();
        logic [7:0] bits;
        logic [7:0] exp_z;
        // 1011 then 0111: the second window never matches.
        bits  = 8'b1011_0111;
        exp_z = 8'b0001_0000;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, bits[i]);
            checks++;
            if (z_no !== exp_z[i]) begin
                errors++;
                $display("FAIL fresh_a_z bit%0d: got %b expected %b", 8 - i, z_no, exp_z[i]);
            end
        end
        checks++;
        if (cnt_no !== 8'd1) begin
            errors++;
            $display("FAIL fresh_a_count: got %0d expected 1", cnt_no);
        end
        // 1011 then 1011 immediately: second window is fresh and matches.
        bits  = 8'b1011_1011;
        exp_z = 8'b0001_0001;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, bits[i]);
            checks++;
            if (z_no !== exp_z[i]) begin
                errors++;
                $display("FAIL fresh_b_z bit%0d: got %b expected %b", 8 - i, z_no, exp_z[i]);
            end
        end
        checks++;
        if (cnt_no !== 8'd2) begin
            errors++;
            $display("FAIL fresh_b_count: got %0d expected 2", cnt_no);
        end
    endtask

    task automatic test_en_gating();
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0]);
            checks++;
            if (z_ov !== 1'b0 || cnt_ov !== 8'd0) begin
                errors++;
                $display("FAIL gate_idle cyc%0d: got z=%b count=%0d expected z=0 count=0", i, z_ov, cnt_ov);
            end
        end
        step(1'b1, 1'b1);
        checks++;
        if (z_ov !== 1'b0) begin
            errors++;
            $display("FAIL gate_bit3_z: got %b expected 0", z_ov);
        end
        step(1'b1, 1'b1);
        checks++;
        if (z_ov !== 1'b1 || cnt_ov !== 8'd1) begin
            errors++;
            $display("FAIL gate_match: got z=%b count=%0d expected z=1 count=1", z_ov, cnt_ov);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0]);
            checks++;
            if (z_ov !== 1'b1 || cnt_ov !== 8'd1) begin
                errors++;
                $display("FAIL gate_hold cyc%0d: got z=%b count=%0d expected z=1 count=1", i, z_ov, cnt_ov);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_z;
        logic [3:0] bits;
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        do_reset();
        // Only after four fresh bits 1,0,1,1 may a match appear.
        bits  = 4'b1011;
        exp_z = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, bits[i]);
            checks++;
            if (z_ov !== exp_z[i]) begin
                errors++;
                $display("FAIL midreset_z bit%0d: got %b expected %b", 4 - i, z_ov, exp_z[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (z_sat !== 1'b1 || cnt_sat !== 2'd1) begin
            errors++;
            $display("FAIL sat_m1: got z=%b count=%0d expected z=1 count=1", z_sat, cnt_sat);
        end
        for (int k = 2; k <= 5; k++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
            step(1'b1, 1'b1);
            exp_cnt = (k > 3) ? 2'd3 : 2'(k);
            checks++;
            if (z_sat !== 1'b1 || cnt_sat !== exp_cnt) begin
                errors++;
                $display("FAIL sat_m%0d: got z=%b count=%0d expected z=1 count=%0d", k, z_sat, cnt_sat, exp_cnt);
            end
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        clr = 1'b1;
        step(1'b1, 1'b1);
        clr = 1'b0;
        checks++;
        if (z_sat !== 1'b1 || cnt_sat !== 2'd0) begin
            errors++;
            $display("FAIL clr_on_match: got z=%b count=%0d expected z=1 count=0", z_sat, cnt_sat);
        end
        step(1'b0, 1'b0);
        checks++;
        if (z_sat !== 1'b1 || cnt_sat !== 2'd0) begin
            errors++;
            $display("FAIL clr_hold: got z=%b count=%0d expected z=1 count=0", z_sat, cnt_sat);
        end
    endtask

    task automatic test_initial_fill();
        logic [7:0] exp_cnt;
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b1);
            exp_cnt = (i >= 4) ? 8'(i - 3) : 8'd0;
            checks++;
            if (z_one !== (i >= 4) || cnt_one !== exp_cnt) begin
                errors++;
                $display("FAIL fill edge%0d: got z=%b count=%0d expected z=%b count=%0d",
                         i, z_one, cnt_one, (i >= 4), exp_cnt);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b0;
        w      = 1'b0;
        clr    = 1'b0;
        @(negedge clk);
        test_reset();
        test_overlap();
        test_nonoverlap_fresh();
        test_en_gating();
        test_reset_mid();
        test_saturation();
        test_initial_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
